tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of divisor and counter.
REQ-002 SHALL have parameter NCH, default 2, number of independent channels.
REQ-003 SHALL have parameter DEF_DIV, default 10000000, divisor loaded into every channel at reset.
REQ-004 SHALL have parameter CHW, default 1, width of channel index (CHW >= $clog2(NCH), min 1).
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: cfg_we  input  1  config write strobe, one write per cycle.
REQ-008 SHALL have port: cfg_ch  input  CHW  target channel of the write.
REQ-009 SHALL have port: cfg_div  input  WIDTH  new divisor; period = cfg_div+1 cycles.
REQ-010 SHALL have port: cfg_mode  input  2  new mode: 00 HALT, 01 RUN, 10 STEP, 11 reserved (treated as HALT).
REQ-011 SHALL have port: step  input  1  single-step request, level, edge-detected internally.
REQ-012 SHALL have port: sync  input  1  synchronous restart of all channels.
REQ-013 SHALL have port: tick  output  NCH  per-channel one-cycle enable pulse, registered.
REQ-014 SHALL have port: sq  output  NCH  per-channel square wave, registered, toggles on each tick.

Function
REQ-015 SHALL keep per channel: counter cnt[WIDTH], divisor div[WIDTH], mode[2], tick and sq flops.
REQ-016 RUN: cnt SHALL increment each cycle; when cnt==div, cnt SHALL wrap to 0, tick SHALL be 1 the next cycle, sq SHALL toggle.
REQ-017 RUN with div=0: tick SHALL be 1 every cycle, sq SHALL toggle every cycle.
REQ-018 RUN: tick period SHALL be exactly div+1 cycles; sq period 2*(div+1) cycles, 50 % duty.
REQ-019 HALT: cnt and sq SHALL hold; tick SHALL be 0.
REQ-020 STEP: cnt SHALL stay 0; on a cycle where step is 1 and was 0 the previous cycle, tick SHALL be 1 for exactly one following cycle and sq SHALL toggle, for every STEP channel.
REQ-021 step held high SHALL produce exactly one step; step in RUN/HALT channels SHALL be ignored.
REQ-022 cfg_we with cfg_ch < NCH SHALL load div and mode of that channel on the next edge, clear its cnt to 0, force its tick to 0 that cycle; sq SHALL hold.
REQ-023 cfg_we with cfg_ch >= NCH SHALL be ignored with no state change.
REQ-024 Write and terminal count on the same channel in the same cycle: write SHALL win, no tick.
REQ-025 Write and step edge on the same STEP channel in the same cycle: write SHALL win, step discarded for that channel only.
REQ-026 sync=1 SHALL clear cnt, tick and sq of all channels on the next edge, keep div and mode; sync SHALL take priority over write, terminal count and step.
REQ-027 Counter comparison SHALL be unsigned WIDTH-bit equality; cnt SHALL never exceed div.
REQ-028 Channels SHALL be fully independent except for shared sync, step and the config port.

Reset
REQ-029 reset=0 SHALL asynchronously set every cnt=0, div=DEF_DIV, mode=RUN, tick=0, sq=0, step edge register=0.
REQ-030 After reset release, first tick on each channel SHALL appear DEF_DIV+1 edges later, so the default behaves as a free-running divider of period 2*(DEF_DIV+1) on sq.
REQ-031 reset asserted mid-period SHALL abort the period; no partial tick SHALL be emitted.

Verification
REQ-032 DEF_DIV=3, NCH=2, release reset, free run 40 cycles -> tick[0],tick[1] high every 4th cycle (first at edge 4), sq toggles with period 8.
REQ-033 Write ch1 div=0 mode RUN at cycle 10 -> tick[1] high every cycle from cycle 12, ch0 unchanged period 4.
REQ-034 Write ch0 mode STEP; hold step high 5 cycles, low, then pulse twice -> exactly 3 single-cycle tick[0] pulses, sq[0] toggles 3 times, ch1 unaffected.
REQ-035 Write ch0 exactly on cycle where cnt==div -> no tick that cycle, next tick div+1 cycles after write; cfg_ch=2 (NCH=2, CHW=2) write -> no change anywhere.
REQ-036 Assert sync mid-period with both channels RUN -> all tick/sq 0 next cycle, both channels realign, first tick div+1 cycles after sync.
REQ-037 Assert reset for 1 ns between clock edges mid-period -> outputs 0 immediately, div back to DEF_DIV, mode RUN, no stray tick after release.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick/square-wave generator.
// Each channel has its own divisor and mode (HALT/RUN/STEP). The channels share
// the config write port, the single-step input and the sync restart input.
module tick_gen #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 2,
  parameter int DEF_DIV = 10000000,
  parameter int CHW     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic             step,
  input  logic             sync,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] LP_DEF_DIV = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] r_cnt  [NCH];
  logic [WIDTH-1:0] r_div  [NCH];
  mode_t            r_mode [NCH];
  logic [NCH-1:0]   r_tick;
  logic [NCH-1:0]   r_sq;
  logic             r_step_q;
  logic             w_step_edge;

  // A step request counts only on its rising edge, so a held level steps once.
  assign w_step_edge = step & ~r_step_q;

  // Previous-cycle copy of step for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
    end
  end

  // Per-channel counter, config and output flops.
  // Priority per channel: sync, then a config write, then the mode behaviour.
  // The reserved mode encoding falls into the default branch and acts as HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= LP_DEF_DIV;
        r_mode[i] <= MODE_RUN;
      end
      r_tick <= '0;
      r_sq   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_sq[i]   <= 1'b0;
        end else if (cfg_we && (cfg_ch == CHW'(i))) begin
          // Loading a channel restarts its period; the square wave keeps its level.
          r_div[i]  <= cfg_div;
          r_mode[i] <= mode_t'(cfg_mode);
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else begin
          case (r_mode[i])
            MODE_RUN: begin
              if (r_cnt[i] == r_div[i]) begin
                r_cnt[i]  <= '0;
                r_tick[i] <= 1'b1;
                r_sq[i]   <= ~r_sq[i];
              end else begin
                r_cnt[i]  <= r_cnt[i] + WIDTH'(1);
                r_tick[i] <= 1'b0;
              end
            end
            MODE_STEP: begin
              r_cnt[i]  <= '0;
              r_tick[i] <= w_step_edge;
              if (w_step_edge) begin
                r_sq[i] <= ~r_sq[i];
              end
            end
            default: begin
              r_tick[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign tick = r_tick;
  assign sq   = r_sq;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: a behavioural per-channel model predicts {tick,sq}
// for every clock edge and queues it; each scenario pops and compares.
`timescale 1ns/100ps
module tb_tick_gen;

  localparam int W   = 16;
  localparam int NCH = 2;
  localparam int DD  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [1:0]     cfg_mode;
  logic           step;
  logic           sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  int n_checks = 0;
  int n_errors = 0;

  // expected {tick[1:0], sq[1:0]} per edge
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;

  // reference model state
  logic [W-1:0] m_cnt [NCH];
  logic [W-1:0] m_div [NCH];
  logic [1:0]   m_mode[NCH];
  logic [NCH-1:0] m_tick, m_sq;
  logic         m_stepq;

  tick_gen #(.WIDTH(W), .NCH(NCH), .DEF_DIV(DD), .CHW(2)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .step(step), .sync(sync),
    .tick(tick), .sq(sq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = '0; m_div[c] = W'(DD); m_mode[c] = 2'b01;
    end
    m_tick = '0; m_sq = '0; m_stepq = 1'b0;
    sb_q.delete();
  endtask

  // Predict the effect of the coming edge from the current inputs, queue it,
  // then let the edge happen and move 1 ns past it.
  task automatic adv();
    bit rise;
    rise = step && !m_stepq;
    for (int c = 0; c < NCH; c++) begin
      if (sync) begin
        m_cnt[c] = '0; m_tick[c] = 1'b0; m_sq[c] = 1'b0;
      end else if (cfg_we && cfg_ch == c) begin
        m_div[c] = cfg_div; m_mode[c] = cfg_mode; m_cnt[c] = '0; m_tick[c] = 1'b0;
      end else if (m_mode[c] == 2'b01) begin
        if (m_cnt[c] == m_div[c]) begin
          m_cnt[c] = '0; m_tick[c] = 1'b1; m_sq[c] = !m_sq[c];
        end else begin
          m_cnt[c] = m_cnt[c] + 1'b1; m_tick[c] = 1'b0;
        end
      end else if (m_mode[c] == 2'b10) begin
        m_cnt[c] = '0; m_tick[c] = rise;
        if (rise) m_sq[c] = !m_sq[c];
      end else begin
        m_tick[c] = 1'b0;
      end
    end
    m_stepq = step;
    sb_q.push_back({m_tick, m_sq});
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [W-1:0] dv, input logic [1:0] md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
    adv();
    cfg_we = 1'b0;
    exp_v = sb_q.pop_front(); n_checks++;
    if ({tick, sq} !== exp_v) begin
      n_errors++; $display("FAIL cfg_write ch%0d got %b exp %b", ch, {tick, sq}, exp_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = '0;
    step = 1'b0; sync = 1'b0;
    #12;
    n_checks++;
    if (tick !== 2'b00) begin n_errors++; $display("FAIL reset_tick got %b exp 00", tick); end
    n_checks++;
    if (sq !== 2'b00) begin n_errors++; $display("FAIL reset_sq got %b exp 00", sq); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    int first = -1;
    int nt = 0;
    for (int k = 1; k <= 40; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL free_run edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[0] && first < 0) first = k;
      if (tick[1]) nt++;
    end
    n_checks++;
    if (first !== 4) begin n_errors++; $display("FAIL free_run_first got %0d exp 4", first); end
    n_checks++;
    if (nt !== 10) begin n_errors++; $display("FAIL free_run_count got %0d exp 10", nt); end
  endtask

  task automatic test_div0();
    int nt = 0;
    cfg_write(2'd1, '0, 2'b01);
    for (int k = 1; k <= 12; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL div0 edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[1]) nt++;
    end
    n_checks++;
    if (nt !== 12) begin n_errors++; $display("FAIL div0_count got %0d exp 12", nt); end
  endtask

  task automatic test_step();
    logic pat [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int nt = 0;
    cfg_write(2'd0, W'(DD), 2'b10);
    for (int k = 0; k < 13; k++) begin
      step = pat[k];
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL step idx %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[0]) nt++;
    end
    step = 1'b0;
    n_checks++;
    if (nt !== 3) begin n_errors++; $display("FAIL step_count got %0d exp 3", nt); end
  endtask

  task automatic test_write_tc();
    int first = -1;
    cfg_write(2'd0, W'(DD), 2'b01);
    for (int k = 0; k < 8; k++) begin
      if (m_cnt[0] == m_div[0]) break;
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL tc_pre edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
    end
    cfg_write(2'd0, W'(DD), 2'b01);
    n_checks++;
    if (tick[0] !== 1'b0) begin n_errors++; $display("FAIL tc_write_tick got %b exp 0", tick[0]); end
    for (int k = 1; k <= 6; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL tc_post edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[0] && first < 0) first = k;
    end
    n_checks++;
    if (first !== DD + 1) begin n_errors++; $display("FAIL tc_first got %0d exp %0d", first, DD + 1); end
    // channel index beyond NCH must be ignored everywhere
    cfg_write(2'd2, '0, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL bad_ch edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
    end
  endtask

  task automatic test_sync();
    int f0 = -1;
    int f1 = -1;
    cfg_write(2'd1, W'(DD), 2'b01);
    for (int k = 1; k <= 6; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL sync_pre edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
    end
    sync = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = '0; cfg_mode = 2'b00;
    adv();
    sync = 1'b0; cfg_we = 1'b0;
    exp_v = sb_q.pop_front(); n_checks++;
    if ({tick, sq} !== 4'b0000) begin
      n_errors++; $display("FAIL sync_clear got %b exp 0000", {tick, sq});
    end
    for (int k = 1; k <= 10; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL sync_post edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[0] && f0 < 0) f0 = k;
      if (tick[1] && f1 < 0) f1 = k;
    end
    n_checks++;
    if (f0 !== DD + 1 || f1 !== DD + 1) begin
      n_errors++; $display("FAIL sync_first got %0d/%0d exp %0d", f0, f1, DD + 1);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    cfg_write(2'd0, W'(1), 2'b01);
    for (int k = 1; k <= 5; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL rmid_pre edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
    end
    #3;
    reset = 1'b0;
    #0.5;
    n_checks++;
    if ({tick, sq} !== 4'b0000) begin
      n_errors++; $display("FAIL rmid_async got %b exp 0000", {tick, sq});
    end
    #0.5;
    reset = 1'b1;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      adv();
      exp_v = sb_q.pop_front(); n_checks++;
      if ({tick, sq} !== exp_v) begin
        n_errors++; $display("FAIL rmid_post edge %0d got %b exp %b", k, {tick, sq}, exp_v);
      end
      if (tick[0] && first < 0) first = k;
    end
    n_checks++;
    if (first !== DD + 1) begin n_errors++; $display("FAIL rmid_first got %0d exp %0d", first, DD + 1); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_div0();
    test_step();
    test_write_tc();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
